descrambler_8bit: RTL

DESCRAMBLER_8BIT -- requirements
Module: descrambler_8bit

---
 rtl/descrambler_pkg.sv | 32 +++
 rtl/xor_gate_8bit.sv | 16 +
 rtl/descrambler_8bit.sv | 101 ++++++++++
 3 files changed

// File: rtl/descrambler_pkg.sv
// ---------------------------------------------------------------------------------------------
// descrambler_pkg
// Shared constants and helpers for the 8-bit additive descrambler.
//   TapMask      : feedback taps of x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   DefaultSeed  : LFSR state after reset, also substituted for an all-zero seed
//   lfsr_step    : one Fibonacci shift, new bit enters at bit 0
//   lfsr_advance8: eight shifts, i.e. one keystream byte consumed
//   seed_fix     : maps the lock-up seed 8'h00 to DefaultSeed
// ---------------------------------------------------------------------------------------------
package descrambler_pkg;

   localparam logic [7:0] TapMask     = 8'hB8;
   localparam logic [7:0] DefaultSeed = 8'h01;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & TapMask)};
   endfunction

   function automatic logic [7:0] lfsr_advance8(input logic [7:0] s);
      logic [7:0] v;
      v = s;
      for (int i = 0; i < 8; i++) begin
         v = lfsr_step(v);
      end
      return v;
   endfunction

   function automatic logic [7:0] seed_fix(input logic [7:0] seed);
      return (seed == 8'h00) ? DefaultSeed : seed;
   endfunction

endpackage

// File: rtl/xor_gate_8bit.sv
// ---------------------------------------------------------------------------------------------
// xor_gate_8bit
// Bitwise XOR of two bytes.
//   inA  : first operand
//   inB  : second operand
//   outY : inA ^ inB
// ---------------------------------------------------------------------------------------------
module xor_gate_8bit (
   input  logic [7:0] inA,
   input  logic [7:0] inB,
   output logic [7:0] outY
);

   assign outY = inA ^ inB;

endmodule

// File: rtl/descrambler_8bit.sv
// ---------------------------------------------------------------------------------------------
// descrambler_8bit
// Additive (keystream XOR) descrambler, one byte per clock, single output register with
// pass-through backpressure.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   inLoad   : seed-load strobe; blocks upstream transfers on that cycle
//   inSeed   : LFSR seed, used when inLoad=1 (8'h00 replaced by 8'h01)
//   inData   : scrambled byte from upstream
//   inValid  : upstream byte valid
//   outReady : block can accept a byte this cycle
//   outY     : descrambled byte
//   outValid : outY valid
//   inReady  : downstream accepts outY
//   outCount : bytes accepted since last reset or load (wraps)
// ---------------------------------------------------------------------------------------------
module descrambler_8bit #(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inLoad,
   input  logic [7:0]         inSeed,
   input  logic [7:0]         inData,
   input  logic               inValid,
   output logic               outReady,
   output logic [7:0]         outY,
   output logic               outValid,
   input  logic               inReady,
   output logic [COUNT_W-1:0] outCount
);

   import descrambler_pkg::*;

   localparam logic [COUNT_W-1:0] CountOne = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic [7:0]         r_state;
   logic [7:0]         r_y;
   logic               r_valid;
   logic [COUNT_W-1:0] r_count;

   logic               w_ready;
   logic               w_xfer;
   logic [7:0]         w_xor;
   logic [7:0]         w_state_d;
   logic [7:0]         w_y_d;
   logic               w_valid_d;
   logic [COUNT_W-1:0] w_count_d;

   // Output slot is free when empty or draining this cycle; a load cycle never takes data.
   assign w_ready = (!r_valid || inReady) && !inLoad;
   assign w_xfer  = inValid && w_ready;

   // Keystream byte is the current LFSR state itself (bit 7 is the oldest bit).
   xor_gate_8bit u_xor (
      .inA  (inData),
      .inB  (r_state),
      .outY (w_xor)
   );

   always_comb begin
      w_state_d = r_state;
      w_y_d     = r_y;
      w_valid_d = r_valid;
      w_count_d = r_count;

      if (r_valid && inReady) begin
         w_valid_d = 1'b0;
      end

      if (inLoad) begin
         w_state_d = seed_fix(inSeed);
         w_count_d = '0;
      end else if (w_xfer) begin
         w_state_d = lfsr_advance8(r_state);
         w_y_d     = w_xor;
         w_valid_d = 1'b1;
         w_count_d = r_count + CountOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DefaultSeed;
         r_y     <= 8'h00;
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_state_d;
         r_y     <= w_y_d;
         r_valid <= w_valid_d;
         r_count <= w_count_d;
      end
   end

   assign outReady = w_ready;
   assign outY     = r_y;
   assign outValid = r_valid;
   assign outCount = r_count;

endmodule
